spi_slave_ctrl: RTL and testbench

SPI mode-0 (CPOL=0, CPHA=0) slave/responder, the far end of the team's SPI master built on uni_shift_reg. Oversamples the external SCLK/SS_n/MOSI pins in the system clock domain. Deserialises WIDTH-bit MOSI frames into a parallel word and serialises a pre-loaded parallel word onto MISO. Provides a one-deep TX buffer with a valid/ready handshake toward the local host logic.

---
 rtl/spi_slave_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI mode-0 (CPOL=0, CPHA=0) responder running in the
// i_clk domain. SCLK, SS_n and MOSI are oversampled through two-flop
// synchronisers (plus an edge-detect flop on SCLK and SS_n). MOSI frames of
// WIDTH bits are deserialised into o_rx_data. A one-deep TX buffer, filled
// through a valid/ready handshake, supplies the word shifted out on MISO.
//
// Ports:
//   i_clk, i_rst          system clock (>= 8x SCLK), synchronous active-high reset
//   i_sclk, i_ss_n, i_mosi asynchronous SPI pins from the master
//   o_miso                serial data to the master, 0 while deselected
//   i_tx_data, i_tx_valid, o_tx_ready  TX buffer write handshake
//   o_rx_data, o_rx_valid last complete frame and its one-cycle strobe
//   o_tx_underrun         one-cycle pulse when a frame loads from an empty buffer
//   o_busy                high while selected
//
// state  | meaning
// IDLE   | deselected, MISO held low, SCLK edges ignored
// ACTIVE | selected, shifting RX on SCLK rise and TX on SCLK fall
module spi_slave_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sclk,
  input  logic             i_ss_n,
  input  logic             i_mosi,
  output logic             o_miso,
  input  logic [WIDTH-1:0] i_tx_data,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_rx_valid,
  output logic             o_tx_underrun,
  output logic             o_busy
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic               ss_s1_q, ss_s2_q, ss_s3_q;
  logic               mosi_s1_q, mosi_s2_q;
  logic [WIDTH-1:0]   shift_tx_q, shift_tx_d;
  logic [WIDTH-1:0]   shift_rx_q, shift_rx_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               reload_q, reload_d;
  logic [WIDTH-1:0]   rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               underrun_q, underrun_d;
  logic [WIDTH-1:0]   tx_buf_q, tx_buf_d;
  logic               tx_full_q, tx_full_d;
  logic               miso_q, miso_d;
  logic               busy_q, busy_d;

  logic               sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic               load_req;
  logic [WIDTH-1:0]   rx_next;

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  assign ss_fall   = ~ss_s2_q & ss_s3_q;
  assign ss_rise   = ss_s2_q & ~ss_s3_q;

  always_comb begin
    state_d    = state_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    bit_cnt_d  = bit_cnt_q;
    reload_d   = reload_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    load_req   = 1'b0;
    rx_next    = LSB_FIRST ? {mosi_s2_q, shift_rx_q[WIDTH-1:1]}
                           : {shift_rx_q[WIDTH-2:0], mosi_s2_q};

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        reload_d  = 1'b0;
        if (ss_fall) begin
          state_d    = ST_ACTIVE;
          shift_rx_d = '0;
          load_req   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // Deselect wins over a coincident SCLK edge, so a master that drops
        // SCLK and raises SS_n together does not trigger a trailing reload.
        if (ss_rise) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          reload_d  = 1'b0;
        end else begin
          if (sclk_rise) begin
            shift_rx_d = rx_next;
            if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
              rx_data_d  = rx_next;
              rx_valid_d = 1'b1;
              bit_cnt_d  = '0;
              reload_d   = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          // The fall after the last bit of a frame loads the next word
          // instead of shifting, so back-to-back frames start aligned.
          if (sclk_fall) begin
            if (reload_q) begin
              load_req = 1'b1;
              reload_d = 1'b0;
            end else begin
              shift_tx_d = LSB_FIRST ? (shift_tx_q >> 1) : (shift_tx_q << 1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_req) begin
      if (tx_full_q) begin
        shift_tx_d = tx_buf_q;
        tx_full_d  = 1'b0;
      end else begin
        shift_tx_d = '0;
        underrun_d = 1'b1;
      end
    end

    // A write is only accepted into an empty buffer; if it lands in the same
    // cycle as an underrun load it is kept for the following frame.
    if (i_tx_valid && !tx_full_q) begin
      tx_buf_d  = i_tx_data;
      tx_full_d = 1'b1;
    end

    busy_d = (state_d == ST_ACTIVE);
    miso_d = (state_d == ST_ACTIVE) ?
             (LSB_FIRST ? shift_tx_d[0] : shift_tx_d[WIDTH-1]) : 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      sclk_s1_q  <= 1'b0;
      sclk_s2_q  <= 1'b0;
      sclk_s3_q  <= 1'b0;
      ss_s1_q    <= 1'b0;
      ss_s2_q    <= 1'b0;
      ss_s3_q    <= 1'b0;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      bit_cnt_q  <= '0;
      reload_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sclk_s1_q  <= i_sclk;
      sclk_s2_q  <= sclk_s1_q;
      sclk_s3_q  <= sclk_s2_q;
      ss_s1_q    <= i_ss_n;
      ss_s2_q    <= ss_s1_q;
      ss_s3_q    <= ss_s2_q;
      mosi_s1_q  <= i_mosi;
      mosi_s2_q  <= mosi_s1_q;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      bit_cnt_q  <= bit_cnt_d;
      reload_q   <= reload_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      miso_q     <= miso_d;
      busy_q     <= busy_d;
    end
  end

  assign o_miso        = miso_q;
  assign o_tx_ready    = ~tx_full_q;
  assign o_rx_data     = rx_data_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_tx_underrun = underrun_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: two instances (MSB-first and LSB-first) share the
// SPI pins driven by a behavioural mode-0 master. Expected RX words, MISO
// words and underrun counts come from a queue model of the TX buffer and the
// bit stream the master sends; a monitor pops expected RX words on o_rx_valid.
module tb_spi_slave_ctrl;
  localparam int W = 8;

  logic clk, rst, sclk, ss_n, mosi;
  logic miso0, miso1;
  logic [W-1:0] tx_data0, tx_data1, rx_data0, rx_data1;
  logic tx_valid0, tx_valid1, ready0, ready1;
  logic rx_valid0, rx_valid1, ur0, ur1, busy0, busy1;

  int n_checks = 0;
  int n_fail = 0;
  int ur_seen0 = 0, ur_seen1 = 0, ur_exp0 = 0, ur_exp1 = 0;
  logic [W-1:0] tx_q0[$], tx_q1[$], rxq0[$], rxq1[$];

  spi_slave_ctrl #(.WIDTH(W), .LSB_FIRST(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_ss_n(ss_n), .i_mosi(mosi),
    .o_miso(miso0), .i_tx_data(tx_data0), .i_tx_valid(tx_valid0),
    .o_tx_ready(ready0), .o_rx_data(rx_data0), .o_rx_valid(rx_valid0),
    .o_tx_underrun(ur0), .o_busy(busy0));

  spi_slave_ctrl #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_ss_n(ss_n), .i_mosi(mosi),
    .o_miso(miso1), .i_tx_data(tx_data1), .i_tx_valid(tx_valid1),
    .o_tx_ready(ready1), .o_rx_data(rx_data1), .o_rx_valid(rx_valid1),
    .o_tx_underrun(ur1), .o_busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every RX strobe against the oldest expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid0) begin
        if (rxq0.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rx0_spurious: got valid with data %0h, expected no strobe", rx_data0);
        end else chk("rx0_data", 32'(rx_data0), 32'(rxq0.pop_front()));
      end
      if (rx_valid1) begin
        if (rxq1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rx1_spurious: got valid with data %0h, expected no strobe", rx_data1);
        end else chk("rx1_data", 32'(rx_data1), 32'(rxq1.pop_front()));
      end
      if (ur0) ur_seen0++;
      if (ur1) ur_seen1++;
    end
  end

  // Frame start in the model: take the buffered word or expect an underrun.
  task automatic model_load(output logic [W-1:0] e0, output logic [W-1:0] e1);
    if (tx_q0.size() > 0) e0 = tx_q0.pop_front();
    else begin e0 = '0; ur_exp0++; end
    if (tx_q1.size() > 0) e1 = tx_q1.pop_front();
    else begin e1 = '0; ur_exp1++; end
  endtask

  task automatic host_write(input bit d, input logic [W-1:0] w);
    bit done = 1'b0;
    @(negedge clk);
    if (d) begin tx_data1 = w; tx_valid1 = 1'b1; end
    else begin tx_data0 = w; tx_valid0 = 1'b1; end
    for (int t = 0; t < 200 && !done; t++) begin
      if (d ? ready1 : ready0) begin
        @(posedge clk);
        if (d) tx_q1.push_back(w); else tx_q0.push_back(w);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (d) tx_valid1 = 1'b0; else tx_valid0 = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL host_write_timeout: ready stayed low for 200 cycles, expected 1");
    end
  endtask

  // Mode-0 master: bits taken from mw[15] downward; SS_n rises together with
  // the final SCLK fall. SCLK half period is 8 i_clk cycles.
  task automatic spi_txn(input int nbits, input logic [15:0] mw,
                         input bit mid_en, input logic [W-1:0] mid_w);
    logic [W-1:0] e0, e1, got0, got1, r0, r1;
    logic b;
    int p;
    e0 = '0; e1 = '0; got0 = '0; got1 = '0; r0 = '0; r1 = '0;
    @(negedge clk);
    ss_n = 1'b0;
    mosi = mw[15];
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      p = i % W;
      if (p == 0) begin
        model_load(e0, e1);
        chk("busy0", 32'(busy0), 32'd1);
      end
      b = mw[15-i];
      got0[W-1-p] = miso0;
      got1[p] = miso1;
      r0[W-1-p] = b;
      r1[p] = b;
      if (p == W - 1) begin
        chk("miso0_word", 32'(got0), 32'(e0));
        chk("miso1_word", 32'(got1), 32'(e1));
        rxq0.push_back(r0);
        rxq1.push_back(r1);
      end
      if (i == 2 && mid_en) fork host_write(1'b0, mid_w); join_none
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
      if (i == nbits - 1) ss_n = 1'b1;
      else mosi = mw[14-i];
      repeat (8) @(negedge clk);
    end
    mosi = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy0_idle", 32'(busy0), 32'd0);
    chk("miso0_idle", 32'(miso0), 32'd0);
    chk("underruns0", 32'(ur_seen0), 32'(ur_exp0));
    chk("underruns1", 32'(ur_seen1), 32'(ur_exp1));
    chk("rxq0_drained", 32'(rxq0.size()), 32'd0);
    chk("rxq1_drained", 32'(rxq1.size()), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2 ms, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] e0, e1;
    int nbits, nf;
    rst = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    tx_data0 = '0; tx_data1 = '0; tx_valid0 = 1'b0; tx_valid1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_miso", 32'(miso0), 32'd0);
    chk("rst_ready", 32'(ready0), 32'd1);
    chk("rst_rx_data", 32'(rx_data0), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid0), 32'd0);
    chk("rst_underrun", 32'(ur0), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Single frame: TX A5, RX 3C.
    host_write(1'b0, 8'hA5);
    chk("ready_after_write", 32'(ready0), 32'd0);
    spi_txn(8, 16'h3C00, 1'b0, '0);
    chk("single_rx_data", 32'(rx_data0), 32'h3C);
    chk("ready_after_frame", 32'(ready0), 32'd1);

    // Back-to-back: F0 buffered, 0F written during frame 1.
    host_write(1'b0, 8'hF0);
    spi_txn(16, 16'h96E1, 1'b1, 8'h0F);
    chk("b2b_rx_data", 32'(rx_data0), 32'hE1);

    // Underrun: empty buffer.
    spi_txn(8, 16'hC300, 1'b0, '0);
    chk("underrun_rx_data", 32'(rx_data0), 32'hC3);

    // Abort after 5 bits, then a full frame with 81.
    spi_txn(5, 16'hFF00, 1'b0, '0);
    chk("abort_rx_hold", 32'(rx_data0), 32'hC3);
    spi_txn(8, 16'h8100, 1'b0, '0);
    chk("after_abort_rx", 32'(rx_data0), 32'h81);

    // Reset in the middle of a frame with the buffer full and MISO high.
    host_write(1'b0, 8'hFF);
    @(negedge clk);
    ss_n = 1'b0; mosi = 1'b1;
    model_load(e0, e1);
    repeat (8) @(negedge clk);
    host_write(1'b0, 8'h66);
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      if (i < 2) begin
        sclk = 1'b0;
        repeat (8) @(negedge clk);
      end
    end
    chk("pre_rst_miso", 32'(miso0), 32'd1);
    chk("pre_rst_ready", 32'(ready0), 32'd0);
    rst = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_miso", 32'(miso0), 32'd0);
    chk("midrst_ready", 32'(ready0), 32'd1);
    chk("midrst_rx_data", 32'(rx_data0), 32'd0);
    chk("midrst_rx_valid", 32'(rx_valid0), 32'd0);
    rst = 1'b0;
    tx_q0.delete(); tx_q1.delete();
    repeat (8) @(negedge clk);
    chk("midrst_rx_data_hold", 32'(rx_data0), 32'd0);

    // LSB-first instance: TX 01, MOSI 1,0,0,0,0,0,0,0.
    host_write(1'b1, 8'h01);
    spi_txn(8, 16'h8000, 1'b0, '0);
    chk("lsb_rx_data", 32'(rx_data1), 32'h01);
    chk("msb_rx_same_stream", 32'(rx_data0), 32'h80);

    // Writes while the buffer is full are ignored.
    host_write(1'b0, 8'h3E);
    @(negedge clk);
    tx_data0 = 8'h77; tx_valid0 = 1'b1;
    repeat (3) @(negedge clk);
    tx_valid0 = 1'b0;
    chk("full_ready_low", 32'(ready0), 32'd0);
    spi_txn(8, 16'h5A00, 1'b0, '0);
    spi_txn(8, 16'hA500, 1'b0, '0);

    // Randomised transactions.
    for (int it = 0; it < 24; it++) begin
      if (tx_q0.size() == 0 && $urandom_range(0, 1) == 1) host_write(1'b0, 8'($urandom));
      if (tx_q1.size() == 0 && $urandom_range(0, 1) == 1) host_write(1'b1, 8'($urandom));
      nf = $urandom_range(1, 2);
      nbits = nf * W;
      if ($urandom_range(0, 4) == 0) nbits = $urandom_range(1, nf * W - 1);
      spi_txn(nbits, 16'($urandom),
              (nf == 2 && tx_q0.size() == 0 && $urandom_range(0, 1) == 1),
              8'($urandom));
    end

    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
